// File: rtl/survival_mode_game_sequencer.sv
// Survival-mode round/life sequencer: launches the two balls, counts lives and
// survival seconds, and decides when the game is over.
module survival_mode_game_sequencer #(
  parameter int LIVES               = 3,
  parameter int LAUNCH_DELAY_FRAMES = 60,
  parameter int BALL2_DELAY_FRAMES  = 300,
  parameter int FRAMES_PER_SECOND   = 30,
  parameter int MAX_SECONDS         = 999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       ball1Lost,
  input  logic       ball2Lost,
  output logic       startGameBall1,
  output logic       startGameBall2,
  output logic       ball1Active,
  output logic       ball2Active,
  output logic [2:0] livesLeft,
  output logic [9:0] survivalSeconds,
  output logic [1:0] gameState,
  output logic       gameOver
);

  localparam int AW = $clog2(LAUNCH_DELAY_FRAMES + 1);
  localparam int BW = $clog2(BALL2_DELAY_FRAMES + 1);
  localparam int FW = $clog2(FRAMES_PER_SECOND + 1);

  localparam logic [AW-1:0] ARM_LOAD  = AW'(LAUNCH_DELAY_FRAMES);
  localparam logic [BW-1:0] B2_LOAD   = BW'(BALL2_DELAY_FRAMES);
  localparam logic [FW-1:0] FRAME_TOP = FW'(FRAMES_PER_SECOND - 1);
  localparam logic [9:0]    SEC_MAX   = 10'(MAX_SECONDS);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t        state;
  logic          keyPrev;
  logic [AW-1:0] armCnt;
  logic [BW-1:0] b2Cnt;
  logic [FW-1:0] frameCnt;

  logic keyEdge;
  logic launch2;
  logic b1Next;
  logic b2Next;
  logic roundEnd;

  // A ball 2 launch in this cycle counts as an active ball, so it keeps the
  // round alive even if ball 1 is lost on the same edge.
  always_comb begin
    keyEdge  = startKey & ~keyPrev;
    launch2  = startOfFrame && (b2Cnt == BW'(1));
    b1Next   = ball1Active & ~ball1Lost;
    b2Next   = (ball2Active & ~ball2Lost) | launch2;
    roundEnd = ~b1Next & ~b2Next;
  end

  assign gameState = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      keyPrev         <= 1'b1;
      armCnt          <= '0;
      b2Cnt           <= '0;
      frameCnt        <= '0;
      startGameBall1  <= 1'b0;
      startGameBall2  <= 1'b0;
      ball1Active     <= 1'b0;
      ball2Active     <= 1'b0;
      livesLeft       <= LIVES_INIT;
      survivalSeconds <= '0;
      gameOver        <= 1'b0;
    end else begin
      keyPrev        <= startKey;
      startGameBall1 <= 1'b0;
      startGameBall2 <= 1'b0;
      case (state)
        IDLE: begin
          if (keyEdge) begin
            livesLeft       <= LIVES_INIT;
            survivalSeconds <= '0;
            frameCnt        <= '0;
            armCnt          <= ARM_LOAD;
            state           <= ARM;
          end
        end
        ARM: begin
          if (startOfFrame) begin
            armCnt <= armCnt - AW'(1);
            if (armCnt == AW'(1)) begin
              state          <= PLAY;
              startGameBall1 <= 1'b1;
              ball1Active    <= 1'b1;
              ball2Active    <= 1'b0;
              b2Cnt          <= B2_LOAD;
            end
          end
        end
        PLAY: begin
          if (startOfFrame) begin
            if (frameCnt == FRAME_TOP) begin
              frameCnt <= '0;
              if (survivalSeconds != SEC_MAX)
                survivalSeconds <= survivalSeconds + 10'd1;
            end else begin
              frameCnt <= frameCnt + FW'(1);
            end
            if (b2Cnt != '0)
              b2Cnt <= b2Cnt - BW'(1);
          end
          if (roundEnd) begin
            ball1Active <= 1'b0;
            ball2Active <= 1'b0;
            livesLeft   <= livesLeft - 3'd1;
            if (livesLeft == 3'd1) begin
              state    <= GAME_OVER;
              gameOver <= 1'b1;
            end else begin
              state  <= ARM;
              armCnt <= ARM_LOAD;
            end
          end else begin
            ball1Active    <= b1Next;
            ball2Active    <= b2Next;
            startGameBall2 <= launch2;
          end
        end
        GAME_OVER: begin
          ball1Active <= 1'b0;
          ball2Active <= 1'b0;
          if (keyEdge) begin
            state    <= IDLE;
            gameOver <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
